// File: rtl/bvugt_bvor_skolem_seq.sv
// Skolem witness generator for (x | s) >u t: reports ic = (t != all-ones) and
// returns either the unsigned-minimal x (bit-serial, MSB first) or all-ones.
module bvugt_bvor_skolem_seq #(
   parameter int W  = 8,
   parameter int CW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_s,
   input  logic [W-1:0] in_t,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_x,
   output logic         out_ic
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [W-1:0]  s_reg, s_next;
   logic [W-1:0]  t_reg, t_next;
   logic [W-1:0]  x_reg, x_next;
   logic          ic_reg, ic_next;
   logic          gt_reg, gt_next;
   logic [CW-1:0] idx_reg, idx_next;

   // tz_vec[i] = 1 iff t has a zero somewhere strictly below bit i
   logic [W-1:0]  tz_vec;
   assign tz_vec[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < W; gi++) begin : g_tz
         assign tz_vec[gi] = ~&t_reg[gi-1:0];
      end
   endgenerate

   logic [W-1:0] s_sh, t_sh, tz_sh;
   logic         s_bit, t_bit, tz_bit, x_bit;

   always_comb begin
      s_sh   = s_reg >> idx_reg;
      t_sh   = t_reg >> idx_reg;
      tz_sh  = tz_vec >> idx_reg;
      s_bit  = s_sh[0];
      t_bit  = t_sh[0];
      tz_bit = tz_sh[0];
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      t_next     = t_reg;
      x_next     = x_reg;
      ic_next    = ic_reg;
      gt_next    = gt_reg;
      idx_next   = idx_reg;
      x_bit      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               s_next   = in_s;
               t_next   = in_t;
               ic_next  = ~&in_t;
               gt_next  = 1'b0;
               idx_next = CW'(W - 1);
               if (&in_t) begin
                  x_next     = '0;
                  state_next = DONE;
               end else if (in_mode) begin
                  x_next     = '1;
                  state_next = DONE;
               end else begin
                  x_next     = '0;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            // Once strictly greater, every remaining bit stays 0 for minimality
            if (gt_reg) begin
               x_bit = 1'b0;
            end else if (s_bit && !t_bit) begin
               x_bit   = 1'b0;
               gt_next = 1'b1;
            end else if (s_bit && t_bit) begin
               x_bit = 1'b0;
            end else if (!s_bit && t_bit) begin
               x_bit = 1'b1;
            end else if (tz_bit) begin
               x_bit = 1'b0;
            end else begin
               x_bit   = 1'b1;
               gt_next = 1'b1;
            end
            x_next = x_reg | ({{(W-1){1'b0}}, x_bit} << idx_reg);
            if (idx_reg == '0) begin
               state_next = DONE;
            end else begin
               idx_next = idx_reg - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         t_reg     <= '0;
         x_reg     <= '0;
         ic_reg    <= 1'b0;
         gt_reg    <= 1'b0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         t_reg     <= t_next;
         x_reg     <= x_next;
         ic_reg    <= ic_next;
         gt_reg    <= gt_next;
         idx_reg   <= idx_next;
      end
   end

   // A minimal-witness run must finish strictly above t
   always_ff @(posedge clk) begin
      if (rst_n && state_reg == RUN && idx_reg == '0) begin
         assert (gt_next);
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign out_x     = x_reg;
   assign out_ic    = ic_reg;

endmodule

// File: tb/tb_bvugt_bvor_skolem_seq.sv
// Directed and randomised checks of bvugt_bvor_skolem_seq at W=8 against a
// brute-force minimal-witness model.
module tb_bvugt_bvor_skolem_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_s;
   logic [W-1:0] in_t;
   logic         in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_x;
   logic         out_ic;

   int checks = 0;
   int errors = 0;

   bvugt_bvor_skolem_seq #(.W(W), .CW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_s      (in_s),
      .in_t      (in_t),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_ic    (out_ic)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_x(input logic [W-1:0] s, input logic [W-1:0] t);
      for (int x = 0; x < (1 << W); x++) begin
         if ((W'(x) | s) > t) return W'(x);
      end
      return '0;
   endfunction

   // One request: checks latency, result, optional backpressure hold, and release
   task automatic run_req(input string tag, input logic [W-1:0] s, input logic [W-1:0] t,
                          input logic mode, input logic [W-1:0] exp_x, input logic exp_ic,
                          input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_s     = s;
      in_t     = t;
      in_mode  = mode;
      @(negedge clk);
      in_valid = 1'b0;
      in_s     = $urandom();
      in_t     = $urandom();
      in_mode  = $urandom_range(0, 1);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " out_x"}, 32'(out_x), 32'(exp_x));
      check({tag, " out_ic"}, 32'(out_ic), 32'(exp_ic));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
         check({tag, " hold out_x"}, 32'(out_x), 32'(exp_x));
         check({tag, " hold out_ic"}, 32'(out_ic), 32'(exp_ic));
         check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
      $display("req %s: s=%02h t=%02h mode=%0d -> x=%02h ic=%0d lat=%0d",
               tag, s, t, mode, exp_x, exp_ic, lat);
   endtask

   initial begin
      logic [W-1:0] rs, rt;
      logic         rm, ric;
      logic         seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_s      = '0;
      in_t      = '0;
      in_mode   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_x", 32'(out_x), 32'd0);
      check("reset out_ic", 32'(out_ic), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;

      run_req("min_00_05", 8'h00, 8'h05, 1'b0, 8'h06, 1'b1, 9, 0);
      run_req("min_0f_0f", 8'h0F, 8'h0F, 1'b0, 8'h10, 1'b1, 9, 0);
      run_req("min_10_0f", 8'h10, 8'h0F, 1'b0, 8'h00, 1'b1, 9, 0);
      run_req("min_ff_fe", 8'hFF, 8'hFE, 1'b0, 8'h00, 1'b1, 9, 0);
      run_req("min_00_00", 8'h00, 8'h00, 1'b0, 8'h01, 1'b1, 9, 0);
      run_req("min_00_fe", 8'h00, 8'hFE, 1'b0, 8'hFF, 1'b1, 9, 0);
      run_req("noic_m0", 8'h3C, 8'hFF, 1'b0, 8'h00, 1'b0, 1, 0);
      run_req("noic_m1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 1, 0);
      run_req("ones_00_05", 8'h00, 8'h05, 1'b1, 8'hFF, 1'b1, 1, 0);
      run_req("backpressure", 8'h0F, 8'h0F, 1'b0, 8'h10, 1'b1, 9, 5);

      // Reset during the third RUN cycle must drop the request
      @(negedge clk);
      in_valid = 1'b1;
      in_s     = 8'h00;
      in_t     = 8'h05;
      in_mode  = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("abort no out_valid", 32'(seen), 32'd0);
      $display("req abort: reset in RUN cycle 3, out_valid seen=%0d", seen);
      run_req("after_abort", 8'h00, 8'h05, 1'b0, 8'h06, 1'b1, 9, 0);

      for (int n = 0; n < 30; n++) begin
         rs  = $urandom();
         rt  = (n % 7 == 3) ? 8'hFF : W'($urandom());
         rm  = (n % 4 == 1);
         ric = (rt != 8'hFF);
         run_req("random", rs, rt, rm,
                 !ric ? 8'h00 : (rm ? 8'hFF : model_x(rs, rt)),
                 ric, (ric && !rm) ? 9 : 1, n % 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bvugt_bvor_skolem_seq.md
Name: bvugt_bvor_skolem_seq

Overview:
- Sequential, width-parametrised Skolem witness generator for the invertibility constraint (x | s) >u t over W-bit bitvectors.
- Accepts an (s, t) pair over a valid/ready handshake and reports the invertibility condition ic = (t != all-ones).
- Produces a witness x: either the unsigned-minimal x (bit-serial, MSB-first, one bit per cycle) or the all-ones witness (single cycle).
- Sits after the operand-extraction stage in the bitvector solving datapath, replacing the fixed-width combinational Skolem netlists.

Parameters:
- W, 8, operand/witness width in bits (W >= 2).
- CW, 4, bit-counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_s  input  W  operand s
- in_t  input  W  bound t
- in_mode  input  1  0 = minimal witness, 1 = all-ones witness
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_x  output  W  witness x
- out_ic  output  1  invertibility condition: 1 iff a witness exists

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - state <- IDLE; out_valid = 0, out_x = 0, out_ic = 0; in_ready = 1 from the next cycle.
  - Reset mid-RUN or mid-DONE aborts the request silently; no result is emitted.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: in_valid & in_ready in cycle k.
  - Latch s, t, mode; compute ic = ~&in_t.
  - If ic = 0: x = 0, go to DONE; out_valid in cycle k+1.
  - Else if mode = 1: x = all-ones, go to DONE; out_valid in cycle k+1.
  - Else: x = 0, cmp = EQ, bit index i = W-1, go to RUN.
- RUN (one bit i per cycle, MSB first). tz(i) = 1 iff t has a 0 in bits i-1..0, with tz(0) = 0.
  - cmp = GT: x_i = 0.
  - cmp = EQ, s_i=1, t_i=0: x_i = 0, cmp <- GT.
  - cmp = EQ, s_i=1, t_i=1: x_i = 0, cmp stays EQ.
  - cmp = EQ, s_i=0, t_i=1: x_i = 1, cmp stays EQ.
  - cmp = EQ, s_i=0, t_i=0: if tz(i) then x_i = 0, EQ; else x_i = 1, cmp <- GT.
  - After processing i = 0, go to DONE. RUN lasts exactly W cycles; out_valid in cycle k+W+1.
- Result property when ic = 1 and mode = 0:
  - (x | s) >u t holds.
  - x is the unsigned minimum of all such x.
  - Final cmp must be GT. An assertion flags EQ at exit.
- DONE:
  - out_x and out_ic stay stable while out_valid & ~out_ready.
  - On out_ready, go to IDLE. in_ready rises the cycle after the result handshake.
  - No request overlaps another: throughput is 1 per W+2 cycles in mode 0 and 1 per 2 cycles in mode 1 or when ic = 0.
- Arithmetic:
  - Unsigned throughout; no carries.
  - tz is computed combinationally from the latched t and bit index, or by a precomputed suffix-OR of ~t.
  - The bit counter never wraps: RUN exits when i = 0 is processed.
- in_s, in_t and in_mode are ignored when not accepted.

Test Plan:
- W=8, mode 0, s=0x00, t=0x05 -> ic=1, x=0x06; out_valid exactly 9 cycles after the accept cycle.
- W=8, mode 0, s=0x0F, t=0x0F -> x=0x10. s=0x10, t=0x0F -> x=0x00. s=0xFF, t=0xFE -> x=0x00.
- W=8, t=0xFF, any s and mode -> ic=0, x=0x00, out_valid 1 cycle after accept. Mode 1, s=0x00, t=0x05 -> x=0xFF, ic=1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_x/out_ic stable, in_ready=0 throughout. Release -> in_ready=1 on the next cycle.
- Reset asserted in RUN cycle 3 -> out_valid never rises for that request; in_ready=1 after reset; a new request s=0x00, t=0x05 returns 0x06.
- Randomised, W=4 exhaustive and W=16 random: compare against a reference model of min x with (x|s) >u t. Assert out_valid only in DONE and cmp = GT at RUN exit.
